// File: rtl/eight_bit_serial_subtractor.sv
// ---------------------------------------------------------------------------
// eight_bit_serial_subtractor
//
// Bit-serial subtractor computing diff = (a - b - bin) mod 2^WIDTH and the
// borrow-out, one bit per clock, LSB first. A request is accepted in IDLE,
// WIDTH clocks are spent in SHIFT, then a single DONE cycle presents the
// result with a one-cycle done pulse before returning to IDLE.
//
// Ports
//   clk    in   single clock, all state updates on its rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   begin a subtraction (only looked at in IDLE)
//   a      in   minuend, captured on the accepting edge
//   b      in   subtrahend, captured on the accepting edge
//   bin    in   borrow-in, captured on the accepting edge
//   busy   out  high while bits are being processed (SHIFT)
//   done   out  one-cycle pulse while the result is fresh (DONE)
//   diff   out  result, held until the next completed operation
//   bout   out  borrow-out, 1 iff a < b + bin (unsigned)
// ---------------------------------------------------------------------------
module eight_bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             brw_next;
  logic             d_bit;
  logic             a_bit;
  logic             b_bit;
  logic             last_bit;

  // One full-subtractor cell applied to the bit selected by the counter.
  // The captured operands are indexed rather than shifted so the latched
  // copies stay intact for the whole operation. acc_next is the result
  // vector with the current bit already merged in, which lets the final
  // edge publish the complete difference in the same clock it is formed.
  always_comb begin
    a_bit    = a_q[cnt];
    b_bit    = b_q[cnt];
    d_bit    = a_bit ^ b_bit ^ brw;
    brw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);
    acc_next = acc;
    acc_next[cnt] = d_bit;
    last_bit = (cnt == LAST_BIT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs. busy and done decode directly from the
  // state so they can never disagree with where the FSM actually is.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. Operands are latched on acceptance so later input changes
  // cannot disturb a running operation. diff/bout are only written on the
  // edge that enters DONE; a reset mid-operation clears them and the
  // partial result in acc is simply abandoned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      brw  <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            brw <= bin;
            acc <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          brw <= brw_next;
          if (last_bit) begin
            diff <= acc_next;
            bout <= brw_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/eight_bit_serial_subtractor.md
EIGHT_BIT_SERIAL_SUBTRACTOR -- requirements
Module: eight_bit_serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; only WIDTH=8 is required to be verified.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; one clock, reset synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH, minuend, captured on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH, subtrahend, captured on the accepting edge.
REQ-007 The block SHALL have port bin, input, 1, borrow-in, captured on the accepting edge.
REQ-008 The block SHALL have port busy, output, 1, high while bits are being processed.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port diff, output, WIDTH, result (a - b - bin) mod 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1, borrow-out; 1 iff a < b + bin (unsigned).

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL capture a, b, bin, clear the bit counter to 0, and enter SHIFT.
REQ-014 In SHIFT, each edge SHALL process exactly one bit, LSB first: d_i = a_i ^ b_i ^ brw; brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw); brw is initialised to bin.
REQ-015 Edges E1..E8 SHALL process bits 0..7; after E8 the FSM SHALL enter DONE.
REQ-016 busy SHALL be 1 exactly in the 8 cycles following E0..E7 (i.e. while in SHIFT), and 0 otherwise.
REQ-017 done SHALL be 1 for exactly the one cycle in DONE; after E9 the FSM SHALL return to IDLE.
REQ-018 diff and bout SHALL be updated only on the edge entering DONE and SHALL hold their values until the next entry into DONE.
REQ-019 start SHALL be ignored in SHIFT and DONE; no queuing; a, b, bin changes after E0 SHALL not affect the result.
REQ-020 A start in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back throughput of one result per 10 cycles.
REQ-021 The bit counter SHALL be 3 bits wide and SHALL not wrap within an operation.

Reset
REQ-022 With rst_n=0 at a rising edge, the block SHALL enter IDLE and set busy=0, done=0, diff=0, bout=0, counter=0.
REQ-023 Reset SHALL take priority over start and over any in-progress operation; a partially computed result SHALL be discarded and no done pulse SHALL follow.
REQ-024 After rst_n returns to 1, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-025 The bench SHALL apply a=200, b=55, bin=0, start one cycle -> busy high 8 cycles, done 9 cycles after E0, diff=145, bout=0.
REQ-026 The bench SHALL apply a=5, b=10, bin=0 -> diff=251, bout=1; and a=0, b=0, bin=1 -> diff=255, bout=1.
REQ-027 The bench SHALL apply a=255, b=255, bin=1 -> diff=255, bout=1; and a=0, b=255, bin=0 -> diff=1, bout=1.
REQ-028 The bench SHALL start a=100, b=1, then assert start with a=7, b=7 during SHIFT and change a, b -> second request ignored, diff=99, bout=0, single done pulse.
REQ-029 The bench SHALL assert rst_n=0 at cycle 4 of SHIFT -> busy=0, diff=0, bout=0 next cycle, no done; then a new start a=9, b=3 -> diff=6, bout=0.
REQ-030 The bench SHALL run 15 random (a, b, bin) back-to-back operations and compare diff, bout against (a - b - bin) mod 256 and the borrow rule.
